vdcmul_32b_seq: RTL and testbench

- Area-reduced 32x32 unsigned multiplier controller.
- Time-multiplexes a single 16x16 Vedic multiplier core (vdcmul_16b) over four phases and accumulates the shifted partial products into a 64-bit result.
- Sits in front of/alongside the datapath as a handshaked multiply unit: valid/ready on input, valid/ready on output.
- Used where the four-core combinational vdcmul_32b is too large.

---
 rtl/vdcmul_pkg.sv | 25 ++
 rtl/vdcmul_32b_seq_if.sv | 23 ++
 rtl/vdcmul_16b.sv | 19 +
 rtl/vdcmul_32b_seq.sv | 119 +++++++++++
 tb/tb_vdcmul_32b_seq.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/vdcmul_pkg.sv
// Shared widths, FSM encodings and phase/shift helpers for the sequential 32x32 multiplier.
package vdcmul_pkg;
  localparam int HALF_W = 16;
  localparam int FULL_W = 32;
  localparam int PROD_W = 64;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  typedef logic [1:0] phase_t;
  localparam phase_t PH_LL = 2'd0;
  localparam phase_t PH_LH = 2'd1;
  localparam phase_t PH_HL = 2'd2;
  localparam phase_t PH_HH = 2'd3;

  function automatic logic [5:0] ph_shift(input phase_t ph);
    case (ph)
      PH_LL:        return 6'd0;
      PH_LH, PH_HL: return 6'd16;
      default:      return 6'd32;
    endcase
  endfunction
endpackage

// File: rtl/vdcmul_32b_seq_if.sv
// Operand/result handshake bundle between a requester and the sequential multiplier.
interface vdcmul_32b_seq_if;
  import vdcmul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FULL_W-1:0] x;
  logic [FULL_W-1:0] y;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] prod;
  logic              busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, prod, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, prod, busy
  );
endinterface

// File: rtl/vdcmul_16b.sv
// Combinational 16x16 Vedic multiplier: four 8x8 vertical/crosswise partials summed.
module vdcmul_16b (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_p
);
  logic [15:0] w_ll;
  logic [15:0] w_lh;
  logic [15:0] w_hl;
  logic [15:0] w_hh;
  logic [16:0] w_mid;

  assign w_ll  = {8'b0, i_a[7:0]}  * {8'b0, i_b[7:0]};
  assign w_lh  = {8'b0, i_a[7:0]}  * {8'b0, i_b[15:8]};
  assign w_hl  = {8'b0, i_a[15:8]} * {8'b0, i_b[7:0]};
  assign w_hh  = {8'b0, i_a[15:8]} * {8'b0, i_b[15:8]};
  assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
  assign o_p   = {16'b0, w_ll} + {7'b0, w_mid, 8'b0} + {w_hh, 16'b0};
endmodule

// File: rtl/vdcmul_32b_seq.sv
// 32x32 unsigned multiplier reusing one 16x16 core over four phases into a 64-bit accumulator.
//   state  | meaning
//   IDLE   | ready for operands
//   MUL    | issuing/accumulating the four half-word partial products
//   DONE   | product held on prod until out_ready
module vdcmul_32b_seq #(
  parameter bit PIPE_PP = 1'b0
) (
  input logic             clk,
  input logic             rst,
  vdcmul_32b_seq_if.slave bus
);
  import vdcmul_pkg::*;

  state_t            r_state;
  phase_t            r_phase;
  logic [FULL_W-1:0] r_xq;
  logic [FULL_W-1:0] r_yq;
  logic [PROD_W-1:0] r_acc;
  logic [PROD_W-1:0] r_prod;

  logic [HALF_W-1:0] w_core_a;
  logic [HALF_W-1:0] w_core_b;
  logic [FULL_W-1:0] w_core_p;
  logic [FULL_W-1:0] w_pp_add;
  phase_t            w_ph_add;
  logic              w_add_en;
  logic              w_last;
  logic [PROD_W-1:0] w_acc_nxt;

  always_comb begin
    w_core_a = r_xq[HALF_W-1:0];
    w_core_b = r_yq[HALF_W-1:0];
    case (r_phase)
      PH_LL: begin w_core_a = r_xq[HALF_W-1:0];      w_core_b = r_yq[HALF_W-1:0];      end
      PH_LH: begin w_core_a = r_xq[HALF_W-1:0];      w_core_b = r_yq[FULL_W-1:HALF_W]; end
      PH_HL: begin w_core_a = r_xq[FULL_W-1:HALF_W]; w_core_b = r_yq[HALF_W-1:0];      end
      default: begin w_core_a = r_xq[FULL_W-1:HALF_W]; w_core_b = r_yq[FULL_W-1:HALF_W]; end
    endcase
  end

  vdcmul_16b u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_core_p)
  );

  generate
    if (PIPE_PP) begin : g_pipe
      // The PP register carries its own phase tag so the shift follows the data.
      logic [FULL_W-1:0] r_pp;
      phase_t            r_pp_ph;
      logic              r_pp_vld;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_pp     <= '0;
          r_pp_ph  <= PH_LL;
          r_pp_vld <= 1'b0;
        end else begin
          r_pp     <= w_core_p;
          r_pp_ph  <= r_phase;
          r_pp_vld <= (r_state == S_MUL) && !w_last;
        end
      end

      assign w_pp_add = r_pp;
      assign w_ph_add = r_pp_ph;
      assign w_add_en = r_pp_vld;
    end else begin : g_direct
      assign w_pp_add = w_core_p;
      assign w_ph_add = r_phase;
      assign w_add_en = 1'b1;
    end
  endgenerate

  assign w_last    = (r_state == S_MUL) && w_add_en && (w_ph_add == PH_HH);
  assign w_acc_nxt = r_acc + ({{(PROD_W-FULL_W){1'b0}}, w_pp_add} << ph_shift(w_ph_add));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= PH_LL;
      r_xq    <= '0;
      r_yq    <= '0;
      r_acc   <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_xq    <= bus.x;
            r_yq    <= bus.y;
            r_acc   <= '0;
            r_phase <= PH_LL;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_phase <= r_phase + 2'd1;
          if (w_add_en) r_acc <= w_acc_nxt;
          if (w_last) begin
            r_prod  <= w_acc_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.prod      = r_prod;
endmodule

// File: tb/tb_vdcmul_32b_seq.sv
// Directed checks on the unpipelined unit plus a random handshake stream on the PIPE_PP=1 unit.
module tb_vdcmul_32b_seq;
  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  vdcmul_32b_seq_if a_if ();
  vdcmul_32b_seq_if b_if ();

  vdcmul_32b_seq #(.PIPE_PP(1'b0)) u_dut0 (.clk(clk), .rst(rst0), .bus(a_if));
  vdcmul_32b_seq #(.PIPE_PP(1'b1)) u_dut1 (.clk(clk), .rst(rst1), .bus(b_if));

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic [31:0] xa, input logic [31:0] ya,
                       input logic [63:0] exp_p, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 64'(a_if.in_ready), 64'd1);
    a_if.in_valid  = 1'b1;
    a_if.x         = xa;
    a_if.y         = ya;
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    a_if.x        = '0;
    a_if.y        = '0;
    check({tag, "_busy"}, 64'(a_if.busy), 64'd1);
    lat = 0;
    while (!a_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_prod"}, a_if.prod, exp_p);
    @(posedge clk); #1;
    check({tag, "_ovfall"}, 64'(a_if.out_valid), 64'd0);
    check({tag, "_rdyback"}, 64'(a_if.in_ready), 64'd1);
  endtask

  initial begin : main
    int lat;
    logic seen;
    int sent, recv, cyc, acc_cyc;
    logic prev_ov, need_new;
    logic [31:0] bx, by;
    logic [63:0] q[$];

    rst0 = 1'b1; rst1 = 1'b1;
    a_if.in_valid = 1'b0; a_if.x = '0; a_if.y = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.x = '0; b_if.y = '0; b_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    check("rst_rdy",  64'(a_if.in_ready),  64'd1);
    check("rst_ov",   64'(a_if.out_valid), 64'd0);
    check("rst_busy", 64'(a_if.busy),      64'd0);
    check("rst_prod", a_if.prod,           64'd0);
    check("rst_rdy1", 64'(b_if.in_ready),  64'd1);

    run_a(32'd3,          32'd5,          64'h0000_0000_0000_000F, "basic");
    run_a(32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, "max");
    run_a(32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, "cross");
    run_a(32'hFFFF_0000,  32'h0000_FFFF,  64'h0000_FFFE_0001_0000, "hl_lh");
    run_a(32'h0000_0001,  32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, "one");
    run_a(32'h0000_0000,  32'hDEAD_BEEF,  64'h0000_0000_0000_0000, "zero");
    run_a(32'h1234_5678,  32'h0001_0001,  64'h0000_1234_68AC_5678, "opchg");

    // backpressure
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.x = 32'h0000_1234; a_if.y = 32'h0000_0100; a_if.out_ready = 1'b0;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    lat = 0;
    while (!a_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    check("bp_prod", a_if.prod, 64'h0000_0000_0012_3400);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ov",   64'(a_if.out_valid), 64'd1);
      check("bp_hold", a_if.prod,           64'h0000_0000_0012_3400);
      check("bp_rdy",  64'(a_if.in_ready),  64'd0);
    end
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ovfall", 64'(a_if.out_valid), 64'd0);
    check("bp_rdyup",  64'(a_if.in_ready),  64'd1);

    // reset during phase 2
    @(negedge clk);
    a_if.in_valid = 1'b1; a_if.x = 32'd100; a_if.y = 32'd200;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    check("abort_rdy",  64'(a_if.in_ready), 64'd1);
    check("abort_busy", 64'(a_if.busy),     64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_if.out_valid) seen = 1'b1;
    end
    check("abort_noov", 64'(seen), 64'd0);
    run_a(32'd7, 32'd9, 64'd63, "post_rst");

    // PIPE_PP=1 random back-to-back stream
    sent = 0; recv = 0; cyc = 0; acc_cyc = 0;
    prev_ov = 1'b0; need_new = 1'b1; bx = '0; by = '0;
    while (recv < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (b_if.out_valid && !prev_ov) check("pp_lat", 64'(cyc - acc_cyc - 1), 64'd5);
      prev_ov = b_if.out_valid;
      if (sent < 1000) begin
        if (need_new) begin
          bx = $urandom;
          by = $urandom;
          need_new = 1'b0;
        end
        b_if.in_valid = 1'b1;
        b_if.x = bx;
        b_if.y = by;
      end else begin
        b_if.in_valid = 1'b0;
      end
      b_if.out_ready = ($urandom_range(0, 3) != 0);
      if (b_if.in_valid && b_if.in_ready) begin
        q.push_back({32'b0, bx} * {32'b0, by});
        acc_cyc = cyc;
        sent++;
        need_new = 1'b1;
      end
      if (b_if.out_valid && b_if.out_ready) begin
        if (q.size() == 0) check("pp_dup", 64'd1, 64'd0);
        else check("pp_prod", b_if.prod, q.pop_front());
        recv++;
      end
    end
    check("pp_recv",  64'(recv),     64'd1000);
    check("pp_sent",  64'(sent),     64'd1000);
    check("pp_drain", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
